// File: rtl/smc_seq_calc.sv
// Serial six-device MOSFET calculator: per-beat gm/current evaluation, descending
// insertion sort, and reduction of the selected group of three to an 8-bit result.
module smc_seq_calc (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [1:0] mode,
  input  logic [2:0] W,
  input  logic [2:0] V_GS,
  input  logic [2:0] V_DS,
  output logic       out_valid,
  output logic [7:0] out_n
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_CALC = 2'd2,
    S_OUT  = 2'd3
  } state_t;

  state_t     state_q, state_d;
  logic [1:0] mode_q, mode_d;
  logic [2:0] cnt_q, cnt_d;
  logic [6:0] n_q [6];
  logic [6:0] n_d [6];
  logic       out_valid_q, out_valid_d;
  logic [7:0] out_n_q, out_n_d;

  logic [1:0] cur_mode_s;
  logic [9:0] w10_s, ov10_s, ds10_s;
  logic [6:0] cur_val_s, gm_val_s, val_s;
  logic [6:0] base_s [6];
  logic [6:0] ins_s  [6];
  logic [5:0] gt_s;
  logic [6:0] a_s, b_s, c_s;
  logic [7:0] res_s;

  // Beat value: saturation/triode device equations on the live inputs.
  always_comb begin
    cur_mode_s = (state_q == S_IDLE) ? mode : mode_q;
    w10_s      = {7'd0, W};
    ov10_s     = {7'd0, V_GS - 3'd1};
    ds10_s     = {7'd0, V_DS};
    if (ds10_s >= ov10_s) begin
      cur_val_s = 7'((w10_s * ov10_s * ov10_s) / 10'd3);
      gm_val_s  = 7'((10'd2 * w10_s * ov10_s) / 10'd3);
    end else begin
      cur_val_s = 7'((w10_s * (10'd2 * ov10_s * ds10_s - ds10_s * ds10_s)) / 10'd3);
      gm_val_s  = 7'((10'd2 * w10_s * ds10_s) / 10'd3);
    end
    val_s = cur_mode_s[0] ? cur_val_s : gm_val_s;
  end

  // Insertion into the descending array; beat 1 inserts into a cleared array.
  always_comb begin
    for (int i = 0; i < 6; i++) begin
      base_s[i] = (state_q == S_IDLE) ? 7'd0 : n_q[i];
    end
    for (int i = 0; i < 6; i++) begin
      gt_s[i] = (val_s > base_s[i]);
    end
    ins_s[0] = gt_s[0] ? val_s : base_s[0];
    for (int i = 1; i < 6; i++) begin
      if (gt_s[i]) begin
        ins_s[i] = gt_s[i-1] ? base_s[i-1] : val_s;
      end else begin
        ins_s[i] = base_s[i];
      end
    end
  end

  // Group reduction over the sorted array.
  always_comb begin
    if (mode_q[1]) begin
      a_s = n_q[0]; b_s = n_q[1]; c_s = n_q[2];
    end else begin
      a_s = n_q[3]; b_s = n_q[4]; c_s = n_q[5];
    end
    if (mode_q[0]) begin
      res_s = 8'(({3'd0, a_s} * 10'd3 + {3'd0, b_s} * 10'd4 + {3'd0, c_s} * 10'd5) / 10'd12);
    end else begin
      res_s = 8'(({3'd0, a_s} + {3'd0, b_s} + {3'd0, c_s}) / 10'd3);
    end
  end

  // Next-state logic; in_valid during CALC/OUT is deliberately ignored.
  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    cnt_d       = cnt_q;
    n_d         = n_q;
    out_valid_d = 1'b0;
    out_n_d     = 8'd0;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          mode_d  = mode;
          n_d     = ins_s;
          cnt_d   = 3'd1;
          state_d = S_LOAD;
        end else begin
          cnt_d = 3'd0;
        end
      end
      S_LOAD: begin
        if (in_valid) begin
          n_d = ins_s;
          if (cnt_q == 3'd5) begin
            cnt_d   = 3'd0;
            state_d = S_CALC;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end else begin
          for (int i = 0; i < 6; i++) begin
            n_d[i] = 7'd0;
          end
          cnt_d   = 3'd0;
          state_d = S_IDLE;
        end
      end
      S_CALC: begin
        out_valid_d = 1'b1;
        out_n_d     = res_s;
        state_d     = S_OUT;
      end
      S_OUT: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      mode_q      <= 2'd0;
      cnt_q       <= 3'd0;
      out_valid_q <= 1'b0;
      out_n_q     <= 8'd0;
      for (int i = 0; i < 6; i++) begin
        n_q[i] <= 7'd0;
      end
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_n_q     <= out_n_d;
      for (int i = 0; i < 6; i++) begin
        n_q[i] <= n_d[i];
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_n     = out_n_q;

endmodule

// File: tb/tb_smc_seq_calc.sv
// Self-checking bench for smc_seq_calc: directed bursts, per-cycle comparison
// against a sort-and-reduce reference model, plus literal result checks.
module tb_smc_seq_calc;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [1:0] mode = 2'd0;
  logic [2:0] W = 3'd0, V_GS = 3'd0, V_DS = 3'd0;
  logic       out_valid;
  logic [7:0] out_n;

  smc_seq_calc dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .mode(mode),
    .W(W), .V_GS(V_GS), .V_DS(V_DS), .out_valid(out_valid), .out_n(out_n)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int checks = 0;
  int errors = 0;
  int last_n = -1;

  typedef struct { int c; int v; } exp_t;
  exp_t expq[$];

  localparam logic [17:0] ALL7 = {6{3'd7}};
  localparam logic [17:0] W3   = {6{3'd3}};
  localparam logic [17:0] GASC = {3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2};
  localparam logic [17:0] GDSC = {3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
  localparam logic [17:0] TW   = {3'd1, 3'd1, 3'd1, 3'd6, 3'd1, 3'd1};
  localparam logic [17:0] TG   = {3'd1, 3'd1, 3'd1, 3'd7, 3'd1, 3'd1};
  localparam logic [17:0] TD   = {3'd1, 3'd1, 3'd1, 3'd2, 3'd1, 3'd1};

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  function automatic int dev_val(input bit is_cur, input int w, input int g, input int d);
    int ov;
    ov = g - 1;
    if (d >= ov) return is_cur ? (w * ov * ov) / 3 : (2 * w * ov) / 3;
    return is_cur ? (w * (2 * ov * d - d * d)) / 3 : (2 * w * d) / 3;
  endfunction

  function automatic int model(input logic [1:0] m, input logic [17:0] w,
                               input logic [17:0] g, input logic [17:0] d);
    int v[6];
    int t, a, b, c;
    for (int k = 0; k < 6; k++)
      v[k] = dev_val(m[0], int'(w[3*k +: 3]), int'(g[3*k +: 3]), int'(d[3*k +: 3]));
    for (int i = 0; i < 6; i++)
      for (int j = 0; j < 5 - i; j++)
        if (v[j] < v[j+1]) begin t = v[j]; v[j] = v[j+1]; v[j+1] = t; end
    if (m[1]) begin a = v[0]; b = v[1]; c = v[2]; end
    else      begin a = v[3]; b = v[4]; c = v[5]; end
    return m[0] ? (3 * a + 4 * b + 5 * c) / 12 : (a + b + c) / 3;
  endfunction

  // Per-cycle compare: out_valid only in scheduled slots, out_n zero otherwise.
  always @(negedge clk) begin
    bit ev;
    int en;
    ev = (expq.size() > 0) && (expq[0].c == cyc);
    en = ev ? expq[0].v : 0;
    check("out_valid", int'(out_valid), int'(ev));
    check("out_n", int'(out_n), en);
    if (out_valid) last_n = int'(out_n);
    if (ev) void'(expq.pop_front());
  end

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic burst(input logic [1:0] m, input logic [17:0] w, input logic [17:0] g,
                       input logic [17:0] d, input int nb, input bit extra);
    int e0;
    e0 = cyc;
    if (nb == 6) expq.push_back('{e0 + 7, model(m, w, g, d)});
    for (int k = 0; k < nb; k++) begin
      in_valid = 1'b1;
      mode = (k == 0) ? m : ~m;
      W = w[3*k +: 3]; V_GS = g[3*k +: 3]; V_DS = d[3*k +: 3];
      @(posedge clk); #1;
    end
    if (extra) begin
      repeat (2) begin
        in_valid = 1'b1; mode = ~m; W = 3'd7; V_GS = 3'd7; V_DS = 3'd7;
        @(posedge clk); #1;
      end
    end
    in_valid = 1'b0; mode = 2'd0; W = 3'd0; V_GS = 3'd0; V_DS = 3'd0;
  endtask

  task automatic run_lit(input string name, input logic [1:0] m, input logic [17:0] w,
                         input logic [17:0] g, input logic [17:0] d, input int exp);
    last_n = -1;
    burst(m, w, g, d, 6, 1'b0);
    idle(4);
    check(name, last_n, exp);
  endtask

  initial begin
    // Model pinned to hand-computed values.
    check("model_all7_m3", model(2'd3, ALL7, ALL7, ALL7), 84);
    check("model_asc_m0", model(2'd0, W3, GASC, ALL7), 4);
    check("model_asc_m3", model(2'd3, W3, GASC, ALL7), 24);
    check("model_tri_m3", model(2'd3, TW, TG, TD), 10);
    check("model_tri_m2", model(2'd2, TW, TG, TD), 2);

    idle(3);
    check("reset_out_valid", int'(out_valid), 0);
    check("reset_out_n", int'(out_n), 0);
    rst = 1'b0;
    idle(1);

    run_lit("all7_m3", 2'd3, ALL7, ALL7, ALL7, 84);
    run_lit("asc_m0", 2'd0, W3, GASC, ALL7, 4);
    run_lit("asc_m2", 2'd2, W3, GASC, ALL7, 10);
    run_lit("asc_m1", 2'd1, W3, GASC, ALL7, 4);
    run_lit("asc_m3", 2'd3, W3, GASC, ALL7, 24);
    run_lit("dsc_m0", 2'd0, W3, GDSC, ALL7, 4);
    run_lit("dsc_m2", 2'd2, W3, GDSC, ALL7, 10);
    run_lit("dsc_m1", 2'd1, W3, GDSC, ALL7, 4);
    run_lit("dsc_m3", 2'd3, W3, GDSC, ALL7, 24);
    run_lit("tri_m3", 2'd3, TW, TG, TD, 10);
    run_lit("tri_m2", 2'd2, TW, TG, TD, 2);
    run_lit("tri_m1", 2'd1, TW, TG, TD, 0);

    // Abort after three beats: no strobe may follow.
    last_n = -1;
    burst(2'd3, ALL7, ALL7, ALL7, 3, 1'b0);
    idle(10);
    check("abort_no_result", last_n, -1);
    run_lit("after_abort", 2'd3, ALL7, ALL7, ALL7, 84);

    // Reset while the FSM is in CALC discards the pending result.
    last_n = -1;
    burst(2'd3, W3, GASC, ALL7, 6, 1'b0);
    rst = 1'b1;
    expq.delete();
    #1;
    check("rst_calc_out_valid", int'(out_valid), 0);
    check("rst_calc_out_n", int'(out_n), 0);
    idle(2);
    rst = 1'b0;
    idle(3);
    check("rst_calc_discard", last_n, -1);
    run_lit("after_reset", 2'd3, W3, GASC, ALL7, 24);

    // Back-to-back at the minimum period, with in_valid held through CALC/OUT.
    burst(2'd2, W3, GASC, ALL7, 6, 1'b1);
    burst(2'd1, W3, GDSC, ALL7, 6, 1'b1);
    idle(2);
    last_n = -1;
    burst(2'd3, TW, TG, TD, 6, 1'b0);
    idle(2);
    burst(2'd0, W3, GDSC, ALL7, 6, 1'b0);
    idle(5);
    check("b2b_last", last_n, 4);
    check("queue_drained", expq.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
